// File: rtl/alu_pkt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkt_pkg
//  Brief    : Shared definitions for the UART ALU packet protocol: opcode
//             enumeration, framing constants and the initiator state enum.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkt_pkg;

    // Command opcodes understood by the ALU
    typedef enum logic [7:0] {
        ADD  = 8'h01,
        MUL  = 8'h02,
        DIV  = 8'h03,
        ECHO = 8'hEC
    } opcode_e;

    // Framing constants
    localparam int         HDR_BYTES     = 4;
    localparam int         WORD_BYTES    = 4;
    localparam logic [7:0] RESERVED_BYTE = 8'h00;

    // Initiator framing FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_WAIT    = 2'd3
    } init_state_e;

    // True when the byte is one of the defined opcodes
    function automatic logic is_known_opcode(input logic [7:0] op);
        logic known;
        known = 1'b0;
        case (op)
            8'h01, 8'h02, 8'h03, 8'hEC: known = 1'b1;
            default:                    known = 1'b0;
        endcase
        return known;
    endfunction

endpackage : alu_pkt_pkg
`default_nettype wire

// File: rtl/alu_rsp_collector.sv
`default_nettype none
// ============================================================================
//  Module   : alu_rsp_collector
//  Brief    : Assembles response bytes from the UART RX stream into 32-bit
//             words (LSB byte first), counts the expected words of the
//             current command and holds each word until it is taken.
//             Optional idle timeout enabled by macro ALU_INIT_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module alu_rsp_collector #(
    parameter int CW             = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          arm_i,
    input  logic [CW-1:0] arm_words_i,
    input  logic [7:0]    s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_data_o,
    output logic          armed_o,
    output logic          done_o,
    output logic          timeout_o
);

    localparam logic [CW-1:0] c_one = CW'(1);

    logic          r_armed;
    logic [CW-1:0] r_words_left;
    logic [1:0]    r_byte_idx;
    logic [23:0]   r_asm;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_data;

    logic w_s_hs;
    logic w_rsp_hs;
    logic w_timeout;

    // Unarmed bytes are swallowed; armed bytes stall while a word waits
    assign s_axis_tready = ~r_armed | ~r_rsp_valid;
    assign w_s_hs        = s_axis_tvalid & s_axis_tready;
    assign w_rsp_hs      = r_rsp_valid & rsp_ready_i;

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign armed_o     = r_armed;
    assign done_o      = w_rsp_hs & (r_words_left == c_one);
    assign timeout_o   = w_timeout;

`ifdef ALU_INIT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_idle_cnt;

    assign w_timeout = r_armed & ~r_rsp_valid & ~w_s_hs
                     & (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Idle counter: restarts on any RX byte or when not collecting
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_idle_cnt <= '0;
        end else if (!r_armed || w_s_hs || w_timeout) begin
            r_idle_cnt <= '0;
        end else if (!r_rsp_valid) begin
            r_idle_cnt <= r_idle_cnt + TW'(1);
        end
    end
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign w_timeout            = 1'b0;
`endif

    // Byte assembly, expected-word countdown and response output register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_armed      <= 1'b0;
            r_words_left <= '0;
            r_byte_idx   <= 2'd0;
            r_asm        <= 24'd0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= 32'd0;
        end else if (arm_i) begin
            r_armed      <= 1'b1;
            r_words_left <= arm_words_i;
            r_byte_idx   <= 2'd0;
            r_asm        <= 24'd0;
        end else if (w_timeout) begin
            r_armed    <= 1'b0;
            r_byte_idx <= 2'd0;
            r_asm      <= 24'd0;
        end else begin
            if (w_s_hs && r_armed) begin
                if (r_byte_idx == 2'd3) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= {s_axis_tdata, r_asm};
                    r_byte_idx  <= 2'd0;
                end else begin
                    r_asm      <= {s_axis_tdata, r_asm[23:8]};
                    r_byte_idx <= r_byte_idx + 2'd1;
                end
            end
            if (w_rsp_hs) begin
                r_rsp_valid  <= 1'b0;
                r_words_left <= r_words_left - c_one;
                if (r_words_left == c_one) begin
                    r_armed <= 1'b0;
                end
            end
        end
    end

endmodule : alu_rsp_collector
`default_nettype wire

// File: rtl/alu_cmd_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_initiator
//  Brief    : Host-side initiator for the UART ALU packet protocol. Frames a
//             command (header + operand words) onto the TX byte stream and
//             returns the ALU response as 32-bit words.
//             Optional response timeout enabled by macro ALU_INIT_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module alu_cmd_initiator
    import alu_pkt_pkg::*;
#(
    parameter int  MAX_OPERANDS   = 255,
    parameter int  TIMEOUT_CYCLES = 1000000,
    localparam int CW             = $clog2(MAX_OPERANDS + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [7:0]    cmd_opcode_i,
    input  logic [CW-1:0] cmd_count_i,
    input  logic          opnd_valid_i,
    output logic          opnd_ready_o,
    input  logic [31:0]   opnd_data_i,
    output logic [7:0]    m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    input  logic [7:0]    s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_data_o,
    output logic          busy_o,
    output logic          err_o
);

    localparam logic [CW-1:0] c_one = CW'(1);
    localparam logic [CW-1:0] c_two = CW'(2);

    init_state_e   r_state;
    logic          r_cmd_ready;
    logic          r_tvalid;
    logic [7:0]    r_tdata;
    logic [23:0]   r_shift;
    logic [1:0]    r_byte_left;
    logic [1:0]    r_hdr_idx;
    logic [CW-1:0] r_words_left;
    logic [15:0]   r_len;
    logic          r_err;

    logic          w_cmd_legal;
    logic          w_accept;
    logic          w_reject;
    logic          w_tx_hs;
    logic          w_opnd_ready;
    logic          w_opnd_hs;
    logic [15:0]   w_len;
    logic [CW-1:0] w_arm_words;
    logic          w_armed;
    logic          w_rsp_done;
    logic          w_timeout;
    logic          w_rsp_clear;

    // Command legality: known opcode, N>0, and arithmetic needs two operands
    assign w_cmd_legal = is_known_opcode(cmd_opcode_i)
                       && (cmd_count_i != '0)
                       && ((cmd_opcode_i == ECHO) || (cmd_count_i >= c_two));
    assign w_accept    = cmd_valid_i & r_cmd_ready & w_cmd_legal;
    assign w_reject    = cmd_valid_i & r_cmd_ready & ~w_cmd_legal;

    // Total packet length in bytes, header included
    assign w_len       = 16'(HDR_BYTES) + 16'(WORD_BYTES) * 16'(cmd_count_i);
    assign w_arm_words = (cmd_opcode_i == ECHO) ? cmd_count_i : c_one;

    assign w_tx_hs      = r_tvalid & m_axis_tready;
    assign w_opnd_ready = (r_state == ST_PAYLOAD) & ~r_tvalid & (r_words_left != '0);
    assign w_opnd_hs    = opnd_valid_i & w_opnd_ready;

    // Collector has nothing left to deliver after this cycle
    assign w_rsp_clear  = ~w_armed | w_rsp_done | w_timeout;

    assign cmd_ready_o   = r_cmd_ready;
    assign busy_o        = ~r_cmd_ready;
    assign opnd_ready_o  = w_opnd_ready;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign err_o         = r_err;

    alu_rsp_collector #(
        .CW             (CW),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_collector (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .arm_i         (w_accept),
        .arm_words_i   (w_arm_words),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .armed_o       (w_armed),
        .done_o        (w_rsp_done),
        .timeout_o     (w_timeout)
    );

    // Framing FSM with header sequencer and operand byte shifter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_cmd_ready  <= 1'b1;
            r_tvalid     <= 1'b0;
            r_tdata      <= 8'd0;
            r_shift      <= 24'd0;
            r_byte_left  <= 2'd0;
            r_hdr_idx    <= 2'd0;
            r_words_left <= '0;
            r_len        <= 16'd0;
            r_err        <= 1'b0;
        end else begin
            r_err <= w_reject | w_timeout;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state      <= ST_HDR;
                        r_cmd_ready  <= 1'b0;
                        r_tvalid     <= 1'b1;
                        r_tdata      <= cmd_opcode_i;
                        r_hdr_idx    <= 2'd0;
                        r_words_left <= cmd_count_i;
                        r_len        <= w_len;
                    end
                end
                ST_HDR: begin
                    if (w_tx_hs) begin
                        r_hdr_idx <= r_hdr_idx + 2'd1;
                        case (r_hdr_idx)
                            2'd0:    r_tdata <= RESERVED_BYTE;
                            2'd1:    r_tdata <= r_len[7:0];
                            2'd2:    r_tdata <= r_len[15:8];
                            default: begin
                                r_tvalid <= 1'b0;
                                r_state  <= ST_PAYLOAD;
                            end
                        endcase
                    end
                end
                ST_PAYLOAD: begin
                    if (w_opnd_hs) begin
                        r_tvalid     <= 1'b1;
                        r_tdata      <= opnd_data_i[7:0];
                        r_shift      <= opnd_data_i[31:8];
                        r_byte_left  <= 2'd3;
                        r_words_left <= r_words_left - c_one;
                    end else if (w_tx_hs) begin
                        if (r_byte_left != 2'd0) begin
                            r_tdata     <= r_shift[7:0];
                            r_shift     <= {8'd0, r_shift[23:8]};
                            r_byte_left <= r_byte_left - 2'd1;
                        end else begin
                            r_tvalid <= 1'b0;
                            if (r_words_left == '0) begin
                                if (w_rsp_clear) begin
                                    r_state     <= ST_IDLE;
                                    r_cmd_ready <= 1'b1;
                                end else begin
                                    r_state <= ST_WAIT;
                                end
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_rsp_clear) begin
                        r_state     <= ST_IDLE;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_tvalid    <= 1'b0;
                end
            endcase
        end
    end

endmodule : alu_cmd_initiator
`default_nettype wire

// File: tb/tb_alu_cmd_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_cmd_initiator
//  Brief    : Self-checking bench for alu_cmd_initiator. Plays the command
//             source, the UART link and the ALU; expected bytes and words
//             come from a packet-level model of the protocol.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_cmd_initiator;
    import alu_pkt_pkg::*;

    localparam int MAXO = 255;
    localparam int CW   = $clog2(MAXO + 1);
`ifdef ALU_INIT_TIMEOUT_EN
    localparam int TO = 50;
`else
    localparam int TO = 1000000;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [7:0]    cmd_opcode_i;
    logic [CW-1:0] cmd_count_i;
    logic          opnd_valid_i;
    logic          opnd_ready_o;
    logic [31:0]   opnd_data_i;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [7:0]    s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [31:0]   rsp_data_o;
    logic          busy_o;
    logic          err_o;

    int n_tests = 0;
    int n_fail  = 0;
    int err_cnt = 0;

    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [31:0] rsp_q[$];
    logic [31:0] op_words[$];

    bit         stall_en = 1'b0;
    bit         loop_en  = 1'b0;
    bit         rsp_hold = 1'b0;
    bit         prev_stalled = 1'b0;
    logic [7:0] prev_data = 8'h00;

    alu_cmd_initiator #(
        .MAX_OPERANDS   (MAXO),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_opcode_i  (cmd_opcode_i),
        .cmd_count_i   (cmd_count_i),
        .opnd_valid_i  (opnd_valid_i),
        .opnd_ready_o  (opnd_ready_o),
        .opnd_data_i   (opnd_data_i),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Link/ALU side: records TX bytes, feeds RX bytes, takes response words
    initial begin
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        rsp_ready_i   = 1'b1;
        forever begin
            @(negedge clk_i);
            if (prev_stalled) begin
                check("tx_hold_valid", 32'(m_axis_tvalid), 32'd1);
                check("tx_hold_data", 32'(m_axis_tdata), 32'(prev_data));
            end
            prev_stalled = m_axis_tvalid && !m_axis_tready;
            prev_data    = m_axis_tdata;
            if (m_axis_tvalid && m_axis_tready) begin
                tx_q.push_back(m_axis_tdata);
                if (loop_en && tx_q.size() > HDR_BYTES) rx_q.push_back(m_axis_tdata);
            end
            if (s_axis_tvalid && s_axis_tready && rx_q.size() > 0) void'(rx_q.pop_front());
            if (rsp_valid_o && rsp_ready_i) rsp_q.push_back(rsp_data_o);
            if (err_o) err_cnt++;
            @(posedge clk_i);
            #1;
            m_axis_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            s_axis_tvalid = (rx_q.size() > 0) && (!stall_en || ($urandom_range(0, 2) != 0));
            s_axis_tdata  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
            rsp_ready_i   = !rsp_hold;
        end
    end

    // One full command: model, drive, wait for idle, compare
    task automatic do_cmd(input string tag, input logic [7:0] op, input int n,
                          input bit stall, input bit hold_first, input bit no_rsp);
        logic [7:0]  exp_tx[$];
        logic [31:0] exp_rsp[$];
        logic [15:0] len;
        logic [31:0] res;
        int          err0;
        int          guard;
        tx_q.delete(); rx_q.delete(); rsp_q.delete();
        err0 = err_cnt;
        len  = 16'(4 + 4 * n);
        exp_tx.push_back(op); exp_tx.push_back(8'h00);
        exp_tx.push_back(len[7:0]); exp_tx.push_back(len[15:8]);
        foreach (op_words[i])
            for (int b = 0; b < 4; b++) exp_tx.push_back(op_words[i][8*b +: 8]);
        res = op_words[0];
        for (int i = 1; i < n; i++) begin
            case (op)
                8'h01:   res = res + op_words[i];
                8'h02:   res = res * op_words[i];
                default: res = (op_words[i] != 0) ? res / op_words[i] : 32'hFFFF_FFFF;
            endcase
        end
        if (op == 8'hEC) exp_rsp = op_words;
        else if (!no_rsp) exp_rsp.push_back(res);
        loop_en = (op == 8'hEC); stall_en = stall; rsp_hold = hold_first;

        @(posedge clk_i); #1;
        cmd_valid_i = 1'b1; cmd_opcode_i = op; cmd_count_i = CW'(n);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        check({tag, "_first_tvalid"}, 32'(m_axis_tvalid), 32'd1);
        check({tag, "_first_byte"}, 32'(m_axis_tdata), 32'(op));
        check({tag, "_busy"}, 32'(busy_o), 32'd1);
        if (op != 8'hEC && !no_rsp)
            for (int b = 0; b < 4; b++) rx_q.push_back(res[8*b +: 8]);

        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            opnd_valid_i = 1'b1; opnd_data_i = op_words[i];
            guard = 0;
            do begin
                @(negedge clk_i);
                guard++;
            end while (!opnd_ready_o && guard < 400);
            if (!opnd_ready_o) begin
                check({tag, "_opnd_ready_bound"}, 32'(opnd_ready_o), 32'd1);
                break;
            end
        end
        @(posedge clk_i); #1;
        opnd_valid_i = 1'b0;

        if (hold_first) begin
            guard = 0;
            while (!rsp_valid_o && guard < 400) begin @(negedge clk_i); guard++; end
            check({tag, "_hold_first_valid"}, 32'(rsp_valid_o), 32'd1);
            repeat (20) begin
                @(negedge clk_i);
                check({tag, "_hold_tready"}, 32'(s_axis_tready), 32'd0);
            end
            check({tag, "_hold_rsp_count"}, 32'(rsp_q.size()), 32'd0);
            rsp_hold = 1'b0;
        end

        guard = 0;
        while (!cmd_ready_o && guard < 3000) begin @(negedge clk_i); guard++; end
        check({tag, "_idle"}, 32'(cmd_ready_o), 32'd1);
        check({tag, "_tx_len"}, 32'(tx_q.size()), 32'(exp_tx.size()));
        foreach (exp_tx[i])
            if (i < tx_q.size()) check($sformatf("%s_tx%0d", tag, i), 32'(tx_q[i]), 32'(exp_tx[i]));
        check({tag, "_rsp_len"}, 32'(rsp_q.size()), 32'(exp_rsp.size()));
        foreach (exp_rsp[i])
            if (i < rsp_q.size()) check($sformatf("%s_rsp%0d", tag, i), rsp_q[i], exp_rsp[i]);
        check({tag, "_err_count"}, 32'(err_cnt - err0), no_rsp ? 32'd1 : 32'd0);
        stall_en = 1'b0; loop_en = 1'b0;
    endtask

    // Illegal command: one-cycle error, nothing sent, stays ready
    task automatic do_reject(input string tag, input logic [7:0] op, input int n);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b1; cmd_opcode_i = op; cmd_count_i = CW'(n);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        check({tag, "_err"}, 32'(err_o), 32'd1);
        check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        check({tag, "_ready"}, 32'(cmd_ready_o), 32'd1);
        @(negedge clk_i);
        check({tag, "_err_pulse"}, 32'(err_o), 32'd0);
        check({tag, "_tvalid2"}, 32'(m_axis_tvalid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_opcode_i = 8'h00; cmd_count_i = '0;
        opnd_valid_i = 1'b0; opnd_data_i = 32'd0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_opnd_ready", 32'(opnd_ready_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_data", rsp_data_o, 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        op_words = '{32'd5, 32'd7};
        do_cmd("add", 8'h01, 2, 1'b0, 1'b0, 1'b0);
        op_words = '{32'h11223344, 32'hAABBCCDD};
        do_cmd("echo", 8'hEC, 2, 1'b0, 1'b0, 1'b0);
        op_words = '{32'd5, 32'd7};
        do_cmd("add_stall", 8'h01, 2, 1'b1, 1'b0, 1'b0);
        op_words = '{32'h11223344, 32'hAABBCCDD};
        do_cmd("echo_hold", 8'hEC, 2, 1'b0, 1'b1, 1'b0);

        do_reject("rej_mul_n1", 8'h02, 1);
        do_reject("rej_op55", 8'h55, 2);
        do_reject("rej_echo_n0", 8'hEC, 0);

        // Reset while the sixth TX byte is on the bus
        tx_q.delete(); rx_q.delete(); rsp_q.delete();
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b1; cmd_opcode_i = 8'h01; cmd_count_i = CW'(2);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0; opnd_valid_i = 1'b1; opnd_data_i = 32'd5;
        guard = 0;
        while (tx_q.size() < 5 && guard < 200) begin @(negedge clk_i); guard++; end
        check("rst_mid_reach_byte6", 32'(tx_q.size() >= 5), 32'd1);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1; opnd_valid_i = 1'b0;
        @(negedge clk_i);
        check("rst_mid_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        check("rst_mid_ready", 32'(cmd_ready_o), 32'd1);
        tx_q.delete(); rx_q.delete(); rsp_q.delete();
        op_words = '{32'd5, 32'd7};
        do_cmd("add_after_rst", 8'h01, 2, 1'b0, 1'b0, 1'b0);

        // Randomized commands against the packet model
        for (int k = 0; k < 8; k++) begin
            logic [7:0] op;
            int         n;
            case ($urandom_range(0, 3))
                0:       op = 8'hEC;
                1:       op = 8'h01;
                2:       op = 8'h02;
                default: op = 8'h03;
            endcase
            n = (op == 8'hEC) ? int'($urandom_range(1, 6)) : int'($urandom_range(2, 6));
            op_words.delete();
            for (int i = 0; i < n; i++) op_words.push_back($urandom);
            do_cmd($sformatf("rnd%0d", k), op, n, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

`ifdef ALU_INIT_TIMEOUT_EN
        op_words = '{32'd1, 32'd2};
        do_cmd("timeout", 8'h01, 2, 1'b0, 1'b0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_cmd_initiator
`default_nettype wire
